// File: rtl/mainbus_pkg.sv
// Shared types and default constants for the main-bus arbiter slice.
package mainbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_BURST_LEN     = 4;
  localparam int DEFAULT_GRANT_TIMEOUT = 8;

endpackage

// File: rtl/mainbus_arbiter_if.sv
// Main-bus arbitration signals: primary requests, sampled bus qualifiers, and grant/status outputs.
interface mainbus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               AddrValid;
  logic               rw;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      owner;
  logic               busy;
  logic               xfer_rw;
  logic               xfer_done;
  logic               protocol_err;
  logic               timeout;

  // master: the arbiter itself; slave: primaries and bus observers around it.
  modport master (
    input  req, AddrValid, rw,
    output gnt, owner, busy, xfer_rw, xfer_done, protocol_err, timeout
  );

  modport slave (
    output req, AddrValid, rw,
    input  gnt, owner, busy, xfer_rw, xfer_done, protocol_err, timeout
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester strictly after lastOwner, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      lastOwner,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0]      candIdx [NUM_REQ];
  logic [NUM_REQ-1:0] candReq;

  // Slot gi holds the requester at distance gi+1 from lastOwner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign candIdx[gi] = IW'((int'(lastOwner) + gi + 1) % NUM_REQ);
    assign candReq[gi] = req[candIdx[gi]];
  end

  always_comb begin
    found = |candReq;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (candReq[k]) idx = candIdx[k];
    end
  end

endmodule

// File: rtl/mainbus_arbiter.sv
// Round-robin main-bus arbiter: grant, address cycle, fixed burst, one-cycle turnaround.
// Optional grant-idle revocation is built when MAINBUS_ARB_TIMEOUT_EN is defined.
module mainbus_arbiter
  import mainbus_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int BURST_LEN     = DEFAULT_BURST_LEN,
  parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
  input logic                clk,
  input logic                resetH,
  mainbus_arbiter_if.master  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_GRANT = GRANT;
  localparam logic [1:0] S_XFER  = XFER;
  localparam logic [1:0] S_TURN  = TURN;

  logic [1:0]         stateReg;
  logic [NUM_REQ-1:0] gntReg;
  logic [IW-1:0]      ownerReg;
  logic [IW-1:0]      lastOwner;
  logic               xferRwReg;
  logic               xferDoneReg;
  logic               protocolErrReg;
  logic [BW-1:0]      beatCnt;

  logic               pickFound;
  logic [IW-1:0]      pickIdx;

`ifdef MAINBUS_ARB_TIMEOUT_EN
  localparam int WW = $clog2(GRANT_TIMEOUT + 1);
  logic [WW-1:0] waitCnt;
  logic          timeoutReg;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req       (bus.req),
    .lastOwner (lastOwner),
    .found     (pickFound),
    .idx       (pickIdx)
  );

  always_ff @(posedge clk) begin
    if (resetH) begin
      stateReg       <= S_IDLE;
      gntReg         <= '0;
      ownerReg       <= '0;
      lastOwner      <= IW'(NUM_REQ - 1);
      xferRwReg      <= 1'b0;
      xferDoneReg    <= 1'b0;
      protocolErrReg <= 1'b0;
      beatCnt        <= '0;
`ifdef MAINBUS_ARB_TIMEOUT_EN
      waitCnt        <= '0;
      timeoutReg     <= 1'b0;
`endif
    end else begin
      xferDoneReg    <= 1'b0;
      protocolErrReg <= 1'b0;
`ifdef MAINBUS_ARB_TIMEOUT_EN
      timeoutReg     <= 1'b0;
`endif
      case (stateReg)
        S_IDLE: begin
          if (pickFound) begin
            stateReg  <= S_GRANT;
            gntReg    <= NUM_REQ'(1) << pickIdx;
            ownerReg  <= pickIdx;
            lastOwner <= pickIdx;
`ifdef MAINBUS_ARB_TIMEOUT_EN
            waitCnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (bus.AddrValid) begin
            xferRwReg <= bus.rw;
            beatCnt   <= '0;
            stateReg  <= S_XFER;
          end else if (!bus.req[ownerReg]) begin
            // Withdrawal never drove the bus, so no turnaround is needed.
            stateReg <= S_IDLE;
            gntReg   <= '0;
          end
`ifdef MAINBUS_ARB_TIMEOUT_EN
          else if (waitCnt == WW'(GRANT_TIMEOUT - 1)) begin
            timeoutReg <= 1'b1;
            stateReg   <= S_TURN;
            gntReg     <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        S_XFER: begin
          if (bus.AddrValid) protocolErrReg <= 1'b1;
          // Hold grant through the final beat; turnaround starts the cycle after.
          if (beatCnt == BW'(BURST_LEN)) begin
            stateReg <= S_TURN;
            gntReg   <= '0;
          end else begin
            beatCnt     <= beatCnt + 1'b1;
            xferDoneReg <= (beatCnt == BW'(BURST_LEN - 1));
          end
        end
        S_TURN:  stateReg <= S_IDLE;
        default: stateReg <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt          = gntReg;
  assign bus.owner        = ownerReg;
  assign bus.busy         = (stateReg != S_IDLE);
  assign bus.xfer_rw      = xferRwReg;
  assign bus.xfer_done    = xferDoneReg;
  assign bus.protocol_err = protocolErrReg;
`ifdef MAINBUS_ARB_TIMEOUT_EN
  assign bus.timeout      = timeoutReg;
`else
  assign bus.timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Self-checking bench for mainbus_arbiter: directed vector table, hand sequences, random vs timeline model.
module tb_mainbus_arbiter;

  localparam int NR = 2;
  localparam int BL = 4;
  localparam int GT = 8;
  localparam int NV = 30;

  logic clk;
  logic resetH;

  mainbus_arbiter_if #(.NUM_REQ(NR)) bus();

  mainbus_arbiter #(
    .NUM_REQ       (NR),
    .BURST_LEN     (BL),
    .GRANT_TIMEOUT (GT)
  ) dut (
    .clk    (clk),
    .resetH (resetH),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {resetH, req[1:0], AddrValid, rw}
  // exp = {gnt[1:0], owner, busy, xfer_rw, xfer_done, protocol_err}
  typedef struct {
    logic [4:0] in;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [NV];
  int   checks;
  int   failures;

  // Timeline model state: a transaction is described by the edges at which it was granted and addressed.
  int   n;
  bit   holding;
  int   mOwner, mLast, gntCycle, addrCycle, freeAt, turnCycle;
  bit   mXrw, mDone, mPerr, mTmo;

  int   gCyc[$];
  int   gOwn[$];
  logic prevNz;
  int   held, toCyc, nextOwn;
  bit   sawTo;
  logic [7:0] act, expv;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic int rrPick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (last + k) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelEdge(input logic rst, input logic [NR-1:0] rq, input logic av, input logic rwIn);
    bit was;
    int p;
    mPerr = 1'b0;
    mTmo  = 1'b0;
    if (rst) begin
      holding   = 1'b0;
      mOwner    = 0;
      mLast     = NR - 1;
      mXrw      = 1'b0;
      addrCycle = -1;
      turnCycle = -100;
      freeAt    = n + 1;
    end else begin
      was = holding;
      if (was && addrCycle >= 0) begin
        if (av) mPerr = 1'b1;
        if (n == addrCycle + BL + 1) begin
          holding   = 1'b0;
          turnCycle = n;
          freeAt    = n + 2;
        end
      end else if (was) begin
        if (av) begin
          addrCycle = n;
          mXrw      = rwIn;
        end else if (!rq[mOwner]) begin
          holding = 1'b0;
          freeAt  = n + 1;
        end
`ifdef MAINBUS_ARB_TIMEOUT_EN
        else if (n - gntCycle == GT) begin
          holding   = 1'b0;
          turnCycle = n;
          freeAt    = n + 2;
          mTmo      = 1'b1;
          mLast     = mOwner;
        end
`endif
      end else if (n >= freeAt) begin
        p = rrPick(rq, mLast);
        if (p >= 0) begin
          holding   = 1'b1;
          mOwner    = p;
          mLast     = p;
          gntCycle  = n;
          addrCycle = -1;
        end
      end
    end
    mDone = (addrCycle >= 0) && (n == addrCycle + BL);
    expv = {(holding ? 2'(1 << mOwner) : 2'b00), 1'(mOwner), holding || (turnCycle == n),
            mXrw, mDone, mPerr, mTmo};
    n++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    resetH        = 1'b1;
    bus.req       = '0;
    bus.AddrValid = 1'b0;
    bus.rw        = 1'b0;

    vecs[0]  = '{5'b1_00_0_0, 7'b00_0_0_0_0_0};
    vecs[1]  = '{5'b0_01_0_0, 7'b01_0_1_0_0_0};
    vecs[2]  = '{5'b0_01_1_1, 7'b01_0_1_1_0_0};
    vecs[3]  = '{5'b0_01_0_0, 7'b01_0_1_1_0_0};
    vecs[4]  = '{5'b0_01_0_0, 7'b01_0_1_1_0_0};
    vecs[5]  = '{5'b0_01_0_0, 7'b01_0_1_1_0_0};
    vecs[6]  = '{5'b0_01_0_0, 7'b01_0_1_1_1_0};
    vecs[7]  = '{5'b0_00_0_0, 7'b00_0_1_1_0_0};
    vecs[8]  = '{5'b0_00_0_0, 7'b00_0_0_1_0_0};
    vecs[9]  = '{5'b0_10_0_0, 7'b10_1_1_1_0_0};
    vecs[10] = '{5'b0_00_0_0, 7'b00_1_0_1_0_0};
    vecs[11] = '{5'b0_00_0_0, 7'b00_1_0_1_0_0};
    vecs[12] = '{5'b0_01_0_0, 7'b01_0_1_1_0_0};
    vecs[13] = '{5'b0_01_1_0, 7'b01_0_1_0_0_0};
    vecs[14] = '{5'b0_01_0_0, 7'b01_0_1_0_0_0};
    vecs[15] = '{5'b0_01_0_0, 7'b01_0_1_0_0_0};
    vecs[16] = '{5'b0_01_1_0, 7'b01_0_1_0_0_1};
    vecs[17] = '{5'b0_01_0_0, 7'b01_0_1_0_1_0};
    vecs[18] = '{5'b0_00_0_0, 7'b00_0_1_0_0_0};
    vecs[19] = '{5'b0_00_0_0, 7'b00_0_0_0_0_0};
    vecs[20] = '{5'b0_10_0_0, 7'b10_1_1_0_0_0};
    vecs[21] = '{5'b0_10_1_1, 7'b10_1_1_1_0_0};
    vecs[22] = '{5'b0_10_0_0, 7'b10_1_1_1_0_0};
    vecs[23] = '{5'b0_10_0_0, 7'b10_1_1_1_0_0};
    vecs[24] = '{5'b1_10_0_0, 7'b00_0_0_0_0_0};
    vecs[25] = '{5'b0_00_0_0, 7'b00_0_0_0_0_0};
    vecs[26] = '{5'b0_11_0_0, 7'b01_0_1_0_0_0};
    vecs[27] = '{5'b0_10_0_0, 7'b00_0_0_0_0_0};
    vecs[28] = '{5'b0_10_0_0, 7'b10_1_1_0_0_0};
    vecs[29] = '{5'b1_00_0_0, 7'b00_0_0_0_0_0};

    // Directed table: single requester, withdrawal, protocol error, reset mid-burst.
    for (int i = 0; i < NV; i++) begin
      resetH        = vecs[i].in[4];
      bus.req       = vecs[i].in[3:2];
      bus.AddrValid = vecs[i].in[1];
      bus.rw        = vecs[i].in[0];
      step();
      act = {bus.gnt, bus.owner, bus.busy, bus.xfer_rw, bus.xfer_done, bus.protocol_err, bus.timeout};
      $display("vec %0d in=%b out=%b", i, vecs[i].in, act);
      check($sformatf("vec%0d", i), int'(act), int'({vecs[i].exp, 1'b0}));
    end

    // Contention from reset: three back-to-back transactions with immediate address cycles.
    resetH = 1'b1;
    bus.req = 2'b00;
    bus.AddrValid = 1'b0;
    step();
    resetH  = 1'b0;
    bus.req = 2'b11;
    prevNz  = 1'b0;
    for (int c = 0; c < 60 && gCyc.size() < 3; c++) begin
      step();
      bus.AddrValid = 1'b0;
      if (bus.gnt != 2'b00 && !prevNz) begin
        gCyc.push_back(c);
        gOwn.push_back(int'(bus.owner));
        $display("rr grant cycle=%0d owner=%0d", c, bus.owner);
        bus.AddrValid = 1'b1;
        bus.rw        = 1'b0;
      end
      prevNz = (bus.gnt != 2'b00);
    end
    check("rr_grants", gCyc.size(), 3);
    if (gCyc.size() == 3) begin
      check("rr_owner0", gOwn[0], 0);
      check("rr_owner1", gOwn[1], 1);
      check("rr_owner2", gOwn[2], 0);
      check("rr_spacing01", gCyc[1] - gCyc[0], BL + 4);
      check("rr_spacing12", gCyc[2] - gCyc[1], BL + 4);
    end
    bus.req = 2'b00;
    bus.AddrValid = 1'b0;
    repeat (10) step();

    // Grantee that never addresses the bus.
    resetH = 1'b1;
    step();
    resetH  = 1'b0;
    bus.req = 2'b11;
`ifdef MAINBUS_ARB_TIMEOUT_EN
    toCyc   = -1;
    nextOwn = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.timeout && toCyc < 0) begin
        toCyc = c;
        check("timeout_gnt", int'(bus.gnt), 0);
      end else if (toCyc >= 0 && bus.gnt != 2'b00 && nextOwn < 0) begin
        nextOwn = int'(bus.owner);
      end
    end
    $display("idle grant timeout cycle=%0d next owner=%0d", toCyc, nextOwn);
    check("timeout_cycle", toCyc, GT);
    check("timeout_next_owner", nextOwn, 1);
`else
    held  = 0;
    sawTo = 1'b0;
    for (int c = 0; c < 2 * GT; c++) begin
      step();
      if (bus.gnt == 2'b01) held++;
      if (bus.timeout) sawTo = 1'b1;
    end
    $display("idle grant held=%0d cycles", held);
    check("hold_cycles", held, 2 * GT);
    check("no_timeout", int'(sawTo), 0);
`endif
    bus.req = 2'b00;
    repeat (4) step();

    // Random traffic against the timeline model.
    n = 0;
    for (int i = 0; i < 800; i++) begin
      resetH = (i == 0) || ($urandom_range(199) == 0);
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(5) == 0) bus.req[b] = ~bus.req[b];
      end
      bus.AddrValid = ($urandom_range(3) == 0);
      bus.rw        = 1'($urandom_range(1));
      modelEdge(resetH, bus.req, bus.AddrValid, bus.rw);
      step();
      act = {bus.gnt, bus.owner, bus.busy, bus.xfer_rw, bus.xfer_done, bus.protocol_err, bus.timeout};
      if (mDone) $display("rand txn done cycle=%0d owner=%0d rw=%0d", i, mOwner, mXrw);
      check($sformatf("rand%0d", i), int'(act), int'(expv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
